// File: rtl/array_port_arbiter.sv
// array_port_arbiter: round-robin arbiter sharing one register file between
// NREQ requesters. One access (write or read) per cycle; read data returns one
// cycle after the grant, tagged with the requester index.
// Optional feature: define ARRAY_ARB_LOCK_EN to add lock_i and owner locking.

// One register-file entry; instanced DEPTH times by the top.
module array_port_arbiter_entry #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Entry storage, cleared on reset, loaded on its decoded write strobe
    always_ff @(posedge clk) begin
        if (rst)     q <= '0;
        else if (we) q <= d;
    end

endmodule

module array_port_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_i,
    input  logic [NREQ-1:0]  we_i,
    input  logic [AW-1:0]    addr_i  [NREQ-1:0],
    input  logic [WIDTH-1:0] wdata_i [NREQ-1:0],
`ifdef ARRAY_ARB_LOCK_EN
    input  logic [NREQ-1:0]  lock_i,
`endif
    output logic [NREQ-1:0]  gnt_o,
    output logic             rvalid_o,
    output logic [PW-1:0]    rid_o,
    output logic [WIDTH-1:0] rdata_o
);

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] k);
        return (int'(k) == NREQ - 1) ? '0 : k + 1'b1;
    endfunction

    logic [PW-1:0]    ptr;
    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    logic             fire;
    logic             we_sel;
    logic [AW-1:0]    addr_sel;
    logic [WIDTH-1:0] wdata_sel;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] mem_we;

`ifdef ARRAY_ARB_LOCK_EN
    logic             own_vld;
    logic [PW-1:0]    own;
    logic             lock_hold;

    // Lock persists only while the owner keeps both req and lock asserted
    assign lock_hold = own_vld && req_i[own] && lock_i[own];
`endif

    // Winner select: locked owner, else first request scanning up from ptr
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
`ifdef ARRAY_ARB_LOCK_EN
        if (lock_hold) begin
            gnt_any = 1'b1;
            gnt_idx = own;
        end else
`endif
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && req_i[(int'(ptr) + i) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // Reset masks the grant so no access can slip through during reset
    assign fire      = gnt_any && !rst;
    assign we_sel    = we_i[gnt_idx];
    assign addr_sel  = addr_i[gnt_idx];
    assign wdata_sel = wdata_i[gnt_idx];

    // One-hot grant vector decoded from the winner index
    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < NREQ; k++)
            gnt_o[k] = fire && (gnt_idx == PW'(k));
    end

    // Register file: only in-range addresses decode to an entry, so
    // out-of-range writes fall on the floor
    for (genvar d = 0; d < DEPTH; d++) begin : g_mem
        assign mem_we[d] = fire && we_sel && (addr_sel == AW'(d));
        array_port_arbiter_entry #(.WIDTH(WIDTH)) u_entry (
            .clk (clk),
            .rst (rst),
            .we  (mem_we[d]),
            .d   (wdata_sel),
            .q   (mem_q[d])
        );
    end

    // Read mux; out-of-range addresses match no entry and read as zero
    always_comb begin
        rd_val = '0;
        for (int d = 0; d < DEPTH; d++)
            if (addr_sel == AW'(d)) rd_val = mem_q[d];
    end

    // Priority pointer: past the winner, frozen under lock, owner+1 on release
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
`ifdef ARRAY_ARB_LOCK_EN
        else if (lock_hold)
            ptr <= ptr;
`endif
        else if (fire)
            ptr <= wrap_inc(gnt_idx);
`ifdef ARRAY_ARB_LOCK_EN
        else if (own_vld)
            ptr <= wrap_inc(own);
`endif
    end

`ifdef ARRAY_ARB_LOCK_EN
    // Owner tracking: a locked grant claims ownership until req or lock drops
    always_ff @(posedge clk) begin
        if (rst) begin
            own_vld <= 1'b0;
            own     <= '0;
        end else if (!lock_hold) begin
            if (fire && lock_i[gnt_idx]) begin
                own_vld <= 1'b1;
                own     <= gnt_idx;
            end else begin
                own_vld <= 1'b0;
            end
        end
    end
`endif

    // Read response: one-cycle pulse with tag and pre-write data
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_o <= 1'b0;
            rid_o    <= '0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= fire && !we_sel;
            if (fire && !we_sel) begin
                rid_o   <= gnt_idx;
                rdata_o <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_array_port_arbiter.sv
// Bench for array_port_arbiter: two instances (DEPTH=4 and DEPTH=3) share
// stimulus; a vector table drives grants, a memory model feeds a response
// scoreboard. Lock rows are included when ARRAY_ARB_LOCK_EN is defined.
module tb_array_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, we, lock;
    logic [1:0] addr  [3:0];
    logic [7:0] wdata [3:0];

    logic [3:0] gnt4, gnt3;
    logic       rv4, rv3;
    logic [1:0] rid4, rid3;
    logic [7:0] rd4, rd3;

    always #5 clk = ~clk;

    array_port_arbiter #(.NREQ(4), .DEPTH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
`ifdef ARRAY_ARB_LOCK_EN
        .lock_i(lock),
`endif
        .gnt_o(gnt4), .rvalid_o(rv4), .rid_o(rid4), .rdata_o(rd4)
    );

    array_port_arbiter #(.NREQ(4), .DEPTH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
`ifdef ARRAY_ARB_LOCK_EN
        .lock_i(lock),
`endif
        .gnt_o(gnt3), .rvalid_o(rv3), .rid_o(rid3), .rdata_o(rd3)
    );

    typedef struct {
        logic        rst_before;
        logic [3:0]  req;
        logic [3:0]  we;
        logic [3:0]  lock;
        logic [7:0]  addr;   // requester k at [2k+:2]
        logic [31:0] wdata;  // requester k at [8k+:8]
        logic [3:0]  gnt;
    } vec_t;

    typedef struct {
        int rid;
        int d4;
        int d3;
    } resp_t;

    vec_t  tbl [$];
    resp_t sbq [$];
    int    m4 [4];
    int    m3 [3];
    int    n_chk  = 0;
    int    n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] w,
                       input logic [3:0] l, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] g);
        vec_t v;
        v.rst_before = r; v.req = rq; v.we = w; v.lock = l;
        v.addr = a; v.wdata = d; v.gnt = g;
        tbl.push_back(v);
    endtask

    task automatic check_resp();
        resp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("rvalid4", int'(rv4), 1);
            chk("rvalid3", int'(rv3), 1);
            chk("rid4", int'(rid4), e.rid);
            chk("rid3", int'(rid3), e.rid);
            chk("rdata4", int'(rd4), e.d4);
            chk("rdata3", int'(rd3), e.d3);
        end else begin
            chk("rvalid4_idle", int'(rv4), 0);
            chk("rvalid3_idle", int'(rv3), 0);
        end
    endtask

    task automatic do_reset();
        req = 4'b1111; we = 4'b0000; lock = 4'b0000;
        rst = 1'b1;
        #1;
        chk("gnt4_in_reset", int'(gnt4), 0);
        chk("gnt3_in_reset", int'(gnt3), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req = 4'b0000;
        sbq.delete();
        for (int i = 0; i < 4; i++) m4[i] = 0;
        for (int i = 0; i < 3; i++) m3[i] = 0;
        chk("rvalid4_post_rst", int'(rv4), 0);
        chk("rvalid3_post_rst", int'(rv3), 0);
        chk("rid4_post_rst", int'(rid4), 0);
        chk("rdata4_post_rst", int'(rd4), 0);
        chk("rdata3_post_rst", int'(rd3), 0);
    endtask

    task automatic step(input vec_t v);
        int a;
        resp_t e;
        if (v.rst_before) do_reset();
        req = v.req; we = v.we; lock = v.lock;
        for (int k = 0; k < 4; k++) begin
            addr[k]  = v.addr[2*k +: 2];
            wdata[k] = v.wdata[8*k +: 8];
        end
        #1;
        chk("gnt4", int'(gnt4), int'(v.gnt));
        chk("gnt3", int'(gnt3), int'(v.gnt));
        for (int k = 0; k < 4; k++) begin
            if (v.gnt[k]) begin
                a = int'(addr[k]);
                if (we[k]) begin
                    m4[a] = int'(wdata[k]);
                    if (a < 3) m3[a] = int'(wdata[k]);
                end else begin
                    e.rid = k;
                    e.d4  = m4[a];
                    e.d3  = (a < 3) ? m3[a] : 0;
                    sbq.push_back(e);
                end
            end
        end
        @(posedge clk); #1;
        check_resp();
    endtask

    initial begin
        vec_t idle;
        rst = 1'b1; req = '0; we = '0; lock = '0;
        for (int k = 0; k < 4; k++) begin
            addr[k] = '0; wdata[k] = '0;
        end
        idle.rst_before = 1'b0; idle.req = '0; idle.we = '0; idle.lock = '0;
        idle.addr = '0; idle.wdata = '0; idle.gnt = '0;

        // reset, then 10 idle cycles
        do_reset();
        for (int i = 0; i < 10; i++) step(idle);

        // first read of every address by requester 0 (ptr 0 -> 1, wraps back to 0)
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0001);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h01, 32'h0, 4'b0001);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h02, 32'h0, 4'b0001);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h03, 32'h0, 4'b0001);
        // requester 2 writes A5 to addr 1, then reads it back
        add(0, 4'b0100, 4'b0100, 4'b0000, 8'h10, 32'h00A5_0000, 4'b0100);
        add(0, 4'b0100, 4'b0000, 4'b0000, 8'h10, 32'h0, 4'b0100);
        // from reset, all four read continuously: 0,1,2,3,0
        add(1, 4'b1111, 4'b0000, 4'b0000, 8'hE4, 32'h0, 4'b0001);
        add(0, 4'b1111, 4'b0000, 4'b0000, 8'hE4, 32'h0, 4'b0010);
        add(0, 4'b1111, 4'b0000, 4'b0000, 8'hE4, 32'h0, 4'b0100);
        add(0, 4'b1111, 4'b0000, 4'b0000, 8'hE4, 32'h0, 4'b1000);
        add(0, 4'b1111, 4'b0000, 4'b0000, 8'hE4, 32'h0, 4'b0001);
        // all write addr k <- 0x10+k, dropping req once granted (ptr 1)
        add(0, 4'b1111, 4'b1111, 4'b0000, 8'hE4, 32'h1312_1110, 4'b0010);
        add(0, 4'b1101, 4'b1111, 4'b0000, 8'hE4, 32'h1312_1110, 4'b0100);
        add(0, 4'b1001, 4'b1111, 4'b0000, 8'hE4, 32'h1312_1110, 4'b1000);
        add(0, 4'b0001, 4'b1111, 4'b0000, 8'hE4, 32'h1312_1110, 4'b0001);
        // all read addr 3-k
        add(0, 4'b1111, 4'b0000, 4'b0000, 8'h1B, 32'h0, 4'b0010);
        add(0, 4'b1101, 4'b0000, 4'b0000, 8'h1B, 32'h0, 4'b0100);
        add(0, 4'b1001, 4'b0000, 4'b0000, 8'h1B, 32'h0, 4'b1000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h1B, 32'h0, 4'b0001);
        // idle holds ptr at 1; then wrap and skip patterns
        add(0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0001);
        add(0, 4'b0101, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0100);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0001);
        // requester 3 withdraws an ungranted write; addr 0 must hold 0x77
        add(0, 4'b1010, 4'b1010, 4'b0000, 8'h00, 32'h9900_7700, 4'b0010);
        add(0, 4'b0000, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0000);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0001);
        // addr 3: in range for DEPTH=4, discarded / reads 0 for DEPTH=3
        add(0, 4'b0001, 4'b0001, 4'b0000, 8'h03, 32'h0000_003C, 4'b0001);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h03, 32'h0, 4'b0001);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h02, 32'h0, 4'b0001);
        add(0, 4'b0001, 4'b0000, 4'b0000, 8'h01, 32'h0, 4'b0001);
        // read by 2 (ptr -> 3), reset, then lowest requester wins and mem is clear
        add(0, 4'b0100, 4'b0000, 4'b0000, 8'h10, 32'h0, 4'b0100);
        add(1, 4'b1100, 4'b0000, 4'b0000, 8'h10, 32'h0, 4'b0100);
`ifdef ARRAY_ARB_LOCK_EN
        // requester 1 locks three accesses while 0 and 3 wait
        add(1, 4'b0001, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0001);
        add(0, 4'b1011, 4'b0000, 4'b0010, 8'h00, 32'h0, 4'b0010);
        add(0, 4'b1011, 4'b0000, 4'b0010, 8'h00, 32'h0, 4'b0010);
        add(0, 4'b1011, 4'b0000, 4'b0010, 8'h00, 32'h0, 4'b0010);
        add(0, 4'b1011, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b1000);
        add(0, 4'b0011, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0001);
        add(0, 4'b0010, 4'b0000, 4'b0000, 8'h00, 32'h0, 4'b0010);
`endif

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // drain: nothing may be outstanding
        step(idle);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/array_port_arbiter.md
# array_port_arbiter

Round-robin arbiter and sequencer that shares one unpacked-array register file, `mem[DEPTH-1:0]` of `WIDTH` bits, between `NREQ` requesters. Each cycle it grants at most one request, either a write or a read. Read data returns one cycle later, tagged with the requester index. It sits in front of the array datapath structures used throughout the array test cases and serves as the shared-access controller for them.

## Interface

- `NREQ`, 4, number of requesters (2..8)
- `DEPTH`, 4, number of array entries (≥2, need not be a power of two)
- `WIDTH`, 8, entry width in bits
- `AW`, `$clog2(DEPTH)`, address width (derived; do not override)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset, sampled on `clk` rising edge
- `req_i`  in  NREQ  per-requester access request
- `we_i`  in  NREQ  per-requester write enable (1 = write, 0 = read)
- `addr_i[NREQ-1:0]`  in  AW each (unpacked)  per-requester address
- `wdata_i[NREQ-1:0]`  in  WIDTH each (unpacked)  per-requester write data
- `lock_i`  in  NREQ  per-requester lock request (present only with `ARRAY_ARB_LOCK_EN`)
- `gnt_o`  out  NREQ  one-hot or zero, combinational grant
- `rvalid_o`  out  1  registered read-response valid
- `rid_o`  out  $clog2(NREQ)  index of the requester the read data belongs to
- `rdata_o`  out  WIDTH  read data

## Operation

- Arbitration: scan `req_i` starting at priority pointer `ptr`, wrapping modulo `NREQ`. The first set bit wins. `gnt_o` asserts that bit only. With no requests, `gnt_o = 0`.
- Handshake: a request completes in a cycle where `req_i[k] & gnt_o[k]`. A requester holds `addr`/`wdata`/`we` stable until granted. Deasserting `req_i` before grant is allowed and has no side effect.
- Pointer update: on a grant to `k`, `ptr <= (k+1) mod NREQ`. With no grant, `ptr` holds.
- Granted write: `mem[addr_i[k]] <= wdata_i[k]`.
- Granted read: next cycle, `rvalid_o=1`, `rid_o=k`, `rdata_o=mem[addr_i[k]]`, using the value before any same-edge write. Only one access happens per cycle, so no collision is possible.
- Out-of-range address (`addr ≥ DEPTH`): the grant and handshake proceed normally. A write is discarded. A read returns `rdata_o=0` with `rvalid_o=1`.
- `rvalid_o` is a one-cycle pulse per granted read. There is no backpressure on responses.

## Timing

- Grant latency: 0 cycles (combinational from `req_i` and registered state).
- Write visibility: a read granted in cycle N+1 sees a write granted in cycle N.
- Read latency: 1 cycle from grant edge to `rvalid_o`.
- Reset (`rst`=1 at an edge): `ptr=0`, every `mem` entry 0, `rvalid_o=0`, `rid_o=0`, `rdata_o=0`, lock owner cleared.
- While `rst` is high, `gnt_o` is forced to 0 and no access occurs.
- Reset mid-operation: an in-flight read response is dropped, so `rvalid_o` is 0 in the cycle after reset.
- Starvation bound: a requester holding `req_i` is granted within `NREQ` cycles when lock is disabled.

## Configuration

- `ARRAY_ARB_LOCK_EN` defined:
  - `lock_i` port exists.
  - A grant to `k` with `lock_i[k]=1` records `k` as owner.
  - While an owner exists, only the owner can be granted, and `ptr` does not advance.
  - The lock releases on the first cycle where the owner has `req_i=0` or `lock_i=0`. That cycle arbitrates normally from `ptr`.
  - Releasing the lock sets `ptr` to owner+1 mod `NREQ`.
- `ARRAY_ARB_LOCK_EN` undefined:
  - No `lock_i` port and no owner state.
  - Pure round-robin.

## Test plan

- Reset, then idle: all outputs 0, `gnt_o=0` for 10 cycles; the first read of each address returns 0.
- Requester 2 writes `0xA5` to addr 1, then reads addr 1 -> `gnt_o=4'b0100` both cycles; one cycle after the read grant, `rvalid_o=1`, `rid_o=2`, `rdata_o=0xA5`.
- All 4 requesters hold reads continuously from reset -> grants 0,1,2,3,0 on consecutive cycles; `rid_o` follows one cycle later.
- With `DEPTH=3`, write `0x3C` to addr 3, then read addr 3 -> write discarded, `rdata_o=0`, `rvalid_o=1`; `mem[0..2]` unchanged.
- Assert `rst` one cycle after a granted read -> `rvalid_o=0` the following cycle, `ptr=0`, and the next grant goes to the lowest requesting index.
- With `ARRAY_ARB_LOCK_EN`: requester 1 locks for 3 accesses while requesters 0 and 3 request -> `gnt_o=4'b0010` for 3 cycles; after `lock_i[1]` drops, the next grant goes to requester 3, then requester 0.
